// File: rtl/reinitializer_multi_rect_pkg.sv
// Shared encodings for the multi-dimensional rectangular reinitializer.
package reinitializer_multi_rect_pkg;

  localparam logic [1:0] MODE_SINGLE     = 2'b00;
  localparam logic [1:0] MODE_REPEAT     = 2'b01;
  localparam logic [1:0] MODE_CONTINUOUS = 2'b10;

  typedef enum logic [2:0] {
    ST_CFG_MODE  = 3'd0,
    ST_CFG_COUNT = 3'd1,
    ST_CFG_MAX   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Raw 2'b11 has no meaning of its own and behaves as a single pass.
  function automatic logic [1:0] decode_mode(input logic [1:0] raw);
    return ((raw == MODE_REPEAT) || (raw == MODE_CONTINUOUS)) ? raw : MODE_SINGLE;
  endfunction

endpackage

// File: rtl/reinitializer_multi_rect_cmp.sv
// Per-dimension comparator: iteration variable against its upper bound.
module reinitializer_multi_rect_cmp #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] ivar_i,
  input  logic signed [W-1:0] max_i,
  output logic                eq_o
);

  // Full-width signed equality; both operands share one width so no extension occurs.
  assign eq_o = (ivar_i == max_i);

endmodule

// File: rtl/reinitializer_multi_rect.sv
// Reinitializer for rectangular iteration spaces: configured over conf_bus,
// then watches the iteration vector and restarts or completes on the last point.
module reinitializer_multi_rect
  import reinitializer_multi_rect_pkg::*;
#(
  parameter int DIMENSION                = 3,
  parameter int SELECT_WIDTH             = 3,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int SELECT_ID                = 6,
  parameter int RUN_COUNT_WIDTH          = 16
) (
  input  logic                                          conf_clk,
  input  logic                                          reset,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0]           conf_bus,
  input  logic                                          conf_valid,
  input  logic [SELECT_WIDTH-1:0]                       sel,
  input  logic [DIMENSION-1:0]                          output_selector,
  input  logic [ITERATION_VARIABLE_WIDTH*DIMENSION-1:0] x_bus,
  input  logic                                          x_valid,
  output logic                                          conf_ack,
  output logic                                          reinitialize,
  output logic                                          gc_done,
  output logic [RUN_COUNT_WIDTH-1:0]                    run_count
);

  localparam int W   = ITERATION_VARIABLE_WIDTH;
  localparam int RCW = RUN_COUNT_WIDTH;
  localparam int KW  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;

  state_e                      state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic [RCW-1:0]              n_q, n_d;
  logic [RCW-1:0]              run_count_q, run_count_d;
  logic [KW-1:0]               k_q, k_d;
  logic [DIMENSION-1:0][W-1:0] max_q, max_d;
  logic [DIMENSION-1:0][W-1:0] ivar;
  logic [DIMENSION-1:0]        eq;
  logic                        reinit_q, reinit_d;
  logic                        done_q, done_d;
  logic                        ack_q, ack_d;
  logic                        wr, last, hit, next_en;
  logic [RCW:0]                count_inc;

  // Dimension 0 occupies the most significant slice of x_bus.
  for (genvar d = 0; d < DIMENSION; d++) begin : g_cmp
    assign ivar[d] = x_bus[W*(DIMENSION-1-d) +: W];
    reinitializer_multi_rect_cmp #(.W(W)) u_cmp (
      .ivar_i (ivar[d]),
      .max_i  (max_q[d]),
      .eq_o   (eq[d])
    );
  end

  assign last      = &eq;
  assign wr        = conf_valid && (sel == SELECT_WIDTH'(SELECT_ID)) && !ack_q;
  assign hit       = (state_q == ST_RUN) && x_valid && last;
  // One extra bit so the repeat comparison never sees a wrapped count.
  assign count_inc = {1'b0, run_count_q} + (RCW+1)'(1);

  // Whether the dimension after the one being loaded is enabled.
  always_comb begin
    next_en = 1'b0;
    for (int d = 0; d < DIMENSION-1; d++)
      if (k_q == KW'(d)) next_en = output_selector[d+1];
  end

  // State register.
  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) state_q <= ST_CFG_MODE;
    else       state_q <= state_d;
  end

  // Next-state: one accepted config word per step, then run until the final pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CFG_MODE:  if (wr) state_d = ST_CFG_COUNT;
      ST_CFG_COUNT: if (wr) state_d = output_selector[0] ? ST_CFG_MAX : ST_RUN;
      ST_CFG_MAX:   if (wr && ((k_q == KW'(DIMENSION-1)) || !next_en)) state_d = ST_RUN;
      ST_RUN: begin
        if (hit) begin
          case (mode_q)
            MODE_REPEAT:     if (count_inc >= {1'b0, n_q}) state_d = ST_DONE;
            MODE_CONTINUOUS: state_d = ST_RUN;
            default:         state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_CFG_MODE;
    endcase
  end

  // Output and datapath next values; everything lands in flops one edge later.
  always_comb begin
    mode_d      = mode_q;
    n_d         = n_q;
    k_d         = k_q;
    max_d       = max_q;
    run_count_d = run_count_q;
    reinit_d    = 1'b0;
    ack_d       = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
    case (state_q)
      ST_CFG_MODE:  if (wr) mode_d = decode_mode(conf_bus[1:0]);
      ST_CFG_COUNT: if (wr) n_d = (conf_bus[RCW-1:0] == '0) ? RCW'(1) : conf_bus[RCW-1:0];
      ST_CFG_MAX: begin
        if (wr) begin
          for (int d = 0; d < DIMENSION; d++)
            if (k_q == KW'(d)) max_d[d] = conf_bus;
          k_d = k_q + KW'(1);
        end
      end
      ST_RUN: begin
        if (hit) begin
          case (mode_q)
            MODE_REPEAT: begin
              run_count_d = count_inc[RCW-1:0];
              reinit_d    = (count_inc < {1'b0, n_q});
            end
            MODE_CONTINUOUS: begin
              run_count_d = count_inc[RCW-1:0];
              reinit_d    = 1'b1;
            end
            default: run_count_d = RCW'(1);
          endcase
        end
      end
      default: ;
    endcase
  end

  // Configuration, counter and registered outputs.
  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_SINGLE;
      n_q         <= '0;
      k_q         <= '0;
      max_q       <= '0;
      run_count_q <= '0;
      reinit_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      n_q         <= n_d;
      k_q         <= k_d;
      max_q       <= max_d;
      run_count_q <= run_count_d;
      reinit_q    <= reinit_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
    end
  end

  assign conf_ack     = ack_q;
  assign reinitialize = reinit_q;
  assign gc_done      = done_q;
  assign run_count    = run_count_q;

endmodule

// File: tb/tb_reinitializer_multi_rect.sv
// Bench for reinitializer_multi_rect: two instances (16-bit and 2-bit run counter)
// share stimulus and are checked every cycle against a behavioural model.
module tb_reinitializer_multi_rect;

  logic        conf_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] conf_bus = '0;
  logic        conf_valid = 1'b0;
  logic [2:0]  sel  = '0;
  logic [2:0]  osel = 3'b111;
  logic [15:0] xv [3];
  logic [47:0] x_bus;
  logic        x_valid = 1'b0;

  logic        ack1, rei1, done1;
  logic [15:0] rc1;
  logic        ack2, rei2, done2;
  logic [1:0]  rc2;

  int ncmp  = 0;
  int nfail = 0;

  assign x_bus = {xv[0], xv[1], xv[2]};

  always #5 conf_clk = ~conf_clk;

  reinitializer_multi_rect u_dut (
    .conf_clk(conf_clk), .reset(reset), .conf_bus(conf_bus), .conf_valid(conf_valid),
    .sel(sel), .output_selector(osel), .x_bus(x_bus), .x_valid(x_valid),
    .conf_ack(ack1), .reinitialize(rei1), .gc_done(done1), .run_count(rc1));

  reinitializer_multi_rect #(.RUN_COUNT_WIDTH(2)) u_dut2 (
    .conf_clk(conf_clk), .reset(reset), .conf_bus(conf_bus), .conf_valid(conf_valid),
    .sel(sel), .output_selector(osel), .x_bus(x_bus), .x_valid(x_valid),
    .conf_ack(ack2), .reinitialize(rei2), .gc_done(done2), .run_count(rc2));

  // Behavioural model, one entry per instance.
  int          m_cnt  [2];
  int          m_mode [2];
  int          m_n    [2];
  int          m_rc   [2];
  bit          m_ack  [2];
  bit          m_done [2];
  bit          m_rei  [2];
  logic [15:0] m_max  [2][3];
  int          mask   [2] = '{65535, 3};

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_mode[u] = 0; m_n[u] = 0; m_rc[u] = 0;
      m_ack[u] = 0; m_done[u] = 0; m_rei[u] = 0;
      for (int d = 0; d < 3; d++) m_max[u][d] = '0;
    end
  endfunction

  // Advance the model by one clock using the inputs presented before the edge.
  function automatic void model_step();
    for (int u = 0; u < 2; u++) begin
      bit wr, last;
      int d;
      wr = conf_valid && (sel == 3'd6) && !m_ack[u];
      last = 1;
      for (int j = 0; j < 3; j++) if (xv[j] != m_max[u][j]) last = 0;
      m_rei[u] = 0;
      if (wr) begin
        if (m_cnt[u] == 0) begin
          m_mode[u] = (conf_bus[1:0] == 2'd1) ? 1 : (conf_bus[1:0] == 2'd2) ? 2 : 0;
          m_cnt[u] = 1;
        end else if (m_cnt[u] == 1) begin
          m_n[u] = int'(conf_bus) & mask[u];
          if (m_n[u] == 0) m_n[u] = 1;
          if (!osel[0]) m_ack[u] = 1; else m_cnt[u] = 2;
        end else begin
          d = m_cnt[u] - 2;
          m_max[u][d] = conf_bus;
          if (d == 2 || !osel[d+1]) m_ack[u] = 1;
          m_cnt[u]++;
        end
      end else if (m_ack[u] && !m_done[u] && x_valid && last) begin
        if (m_mode[u] == 0) begin
          m_done[u] = 1; m_rc[u] = 1;
        end else if (m_mode[u] == 1) begin
          if (m_rc[u] + 1 < m_n[u]) m_rei[u] = 1; else m_done[u] = 1;
          m_rc[u] = (m_rc[u] + 1) & mask[u];
        end else begin
          m_rc[u] = (m_rc[u] + 1) & mask[u];
          m_rei[u] = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ack1"},  int'(ack1),  int'(m_ack[0]));
    chk({tag, ".rei1"},  int'(rei1),  int'(m_rei[0]));
    chk({tag, ".done1"}, int'(done1), int'(m_done[0]));
    chk({tag, ".rc1"},   int'(rc1),   m_rc[0]);
    chk({tag, ".ack2"},  int'(ack2),  int'(m_ack[1]));
    chk({tag, ".rei2"},  int'(rei2),  int'(m_rei[1]));
    chk({tag, ".done2"}, int'(done2), int'(m_done[1]));
    chk({tag, ".rc2"},   int'(rc2),   m_rc[1]);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge conf_clk);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges: outputs must clear before any clock arrives.
  task automatic do_reset(input string tag);
    conf_valid = 0; x_valid = 0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all({tag, ".async"});
    @(posedge conf_clk);
    #1 check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  task automatic word(input string tag, input logic [15:0] w);
    conf_valid = 1; sel = 3'd6; conf_bus = w;
    tick(tag);
    conf_valid = 0;
  endtask

  task automatic noise(input string tag);
    conf_valid = 1; sel = 3'd5; conf_bus = 16'(($urandom & 32'hFFFF));
    tick(tag);
    conf_valid = 0; conf_bus = 16'(($urandom & 32'hFFFF));
    tick(tag);
  endtask

  task automatic hit(input string tag, input logic [15:0] a, b, c);
    xv[0] = a; xv[1] = b; xv[2] = c; x_valid = 1;
    tick(tag);
    x_valid = 0;
  endtask

  initial begin
    logic [2:0] osel_tab [3];
    osel_tab[0] = 3'b001; osel_tab[1] = 3'b011; osel_tab[2] = 3'b111;
    for (int d = 0; d < 3; d++) xv[d] = '0;
    model_reset();
    @(posedge conf_clk);
    #1 check_all("reset");
    reset = 1'b0;

    // SINGLE mode, full config with filtered words interleaved.
    osel = 3'b111;
    word("s.mode", 16'h0000); noise("s.noise");
    word("s.n", 16'd5);       noise("s.noise");
    word("s.m0", 16'd3);
    word("s.m1", 16'd2);      noise("s.noise");
    word("s.m2", 16'd1);
    hit("s.miss", 16'd3, 16'd2, 16'd0);
    hit("s.miss", 16'd0, 16'd2, 16'd1);
    hit("s.last", 16'd3, 16'd2, 16'd1);
    tick("s.after");
    hit("s.again", 16'd3, 16'd2, 16'd1);

    // REPEAT N=3, with ignored writes after conf_ack and back-to-back hits.
    do_reset("r.rst");
    word("r.mode", 16'h0001); word("r.n", 16'd3);
    word("r.m0", 16'd2); word("r.m1", 16'd2); word("r.m2", 16'd2);
    word("r.late", 16'd7); word("r.late", 16'd7);
    hit("r.h1", 16'd2, 16'd2, 16'd2);
    tick("r.gap");
    hit("r.stale", 16'd7, 16'd7, 16'd2);
    xv[0] = 16'd2; xv[1] = 16'd2; xv[2] = 16'd2; x_valid = 1;
    tick("r.h2"); tick("r.h3"); tick("r.h4");
    x_valid = 0;
    tick("r.end");

    // CONTINUOUS: 2-bit counter wraps, gc_done never rises.
    do_reset("c.rst");
    word("c.mode", 16'h0002); word("c.n", 16'd0);
    word("c.m0", 16'd1); word("c.m1", 16'd0); word("c.m2", 16'hFFFF);
    xv[0] = 16'd1; xv[1] = 16'd0; xv[2] = 16'hFFFF; x_valid = 1;
    for (int i = 0; i < 5; i++) tick("c.hit");
    x_valid = 0;
    tick("c.end");

    // Partial config: only dimension 0 loaded, N=0 behaves as 1.
    do_reset("p.rst");
    osel = 3'b001;
    word("p.mode", 16'h0001); word("p.n", 16'd0); word("p.m0", 16'hFFFF);
    hit("p.miss", 16'hFFFF, 16'd0, 16'd5);
    tick("p.idle");
    hit("p.last", 16'hFFFF, 16'd0, 16'd0);
    tick("p.end");

    // Randomised configurations and sample streams.
    for (int r = 0; r < 8; r++) begin
      int guard;
      do_reset("rnd.rst");
      osel = osel_tab[$urandom_range(0, 2)];
      guard = 0;
      while (!m_ack[0] && guard < 200) begin
        int pick;
        pick = $urandom_range(0, 3);
        if (pick == 0) begin
          conf_valid = 1; sel = 3'd5; conf_bus = 16'($urandom_range(0, 3));
        end else if (pick == 1) begin
          conf_valid = 0; conf_bus = 16'($urandom_range(0, 3));
        end else begin
          conf_valid = 1; sel = 3'd6;
          if (m_cnt[0] == 0)      conf_bus = 16'($urandom_range(0, 3));
          else if (m_cnt[0] == 1) conf_bus = 16'($urandom_range(0, 4));
          else                    conf_bus = 16'($urandom_range(0, 2));
        end
        tick("rnd.cfg");
        guard++;
      end
      conf_valid = 0;
      chk("rnd.cfg_bound", int'(guard < 200), 1);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1)
          for (int d = 0; d < 3; d++) xv[d] = m_max[0][d];
        else
          for (int d = 0; d < 3; d++) xv[d] = 16'($urandom_range(0, 2));
        x_valid = ($urandom_range(0, 3) != 0);
        conf_valid = ($urandom_range(0, 4) == 0); sel = 3'd6;
        conf_bus = 16'($urandom_range(0, 2));
        tick("rnd.run");
      end
      x_valid = 0; conf_valid = 0;
    end

    // Reset in the middle of a REPEAT run, then no response without reconfiguration.
    do_reset("m.rst");
    osel = 3'b111;
    word("m.mode", 16'h0001); word("m.n", 16'd3);
    word("m.m0", 16'd1); word("m.m1", 16'd1); word("m.m2", 16'd1);
    hit("m.h1", 16'd1, 16'd1, 16'd1);
    do_reset("m.mid");
    hit("m.post", 16'd0, 16'd0, 16'd0);
    hit("m.post", 16'd1, 16'd1, 16'd1);
    noise("m.noise");
    tick("m.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
